// File: rtl/watchdog_timer.sv
// watchdog_timer: NUM_CH independent watchdog channels with sticky expiry and a
// per-channel shadow timeout. Define WATCHDOG_WARN_EN to enable the pre-expiry WARN state.
module watchdog_timer #(
   parameter int NUM_CH      = 2,
   parameter int CNT_W       = 10,
   parameter int WARN_MARGIN = 8
) (
   input  logic                    clk,
   input  logic                    rstn,
   input  logic [NUM_CH-1:0]       en,
   input  logic [NUM_CH-1:0]       kick,
   input  logic [NUM_CH-1:0]       clear,
   input  logic [NUM_CH*CNT_W-1:0] timeout,
   output logic [NUM_CH-1:0]       warn,
   output logic [NUM_CH-1:0]       expired,
   output logic                    expired_any,
   output logic [NUM_CH*CNT_W-1:0] count_val
);

`ifdef WATCHDOG_WARN_EN
   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_RUN     = 2'd1,
      S_WARN    = 2'd2,
      S_EXPIRED = 2'd3
   } state_t;
`else
   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_RUN     = 2'd1,
      S_EXPIRED = 2'd3
   } state_t;
`endif

   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
`ifdef WATCHDOG_WARN_EN
   localparam logic [CNT_W-1:0] MARGIN_N = CNT_W'(WARN_MARGIN);
   localparam logic [32:0]      MARGIN_X = 33'(WARN_MARGIN);
`endif

   state_t           state_q  [NUM_CH];
   state_t           state_d  [NUM_CH];
   logic [CNT_W-1:0] count_q  [NUM_CH];
   logic [CNT_W-1:0] count_d  [NUM_CH];
   logic [CNT_W-1:0] shadow_q [NUM_CH];
   logic [CNT_W-1:0] shadow_d [NUM_CH];
   logic [CNT_W-1:0] tmo_s    [NUM_CH];
   logic [CNT_W-1:0] cnt_inc_s[NUM_CH];
   logic [NUM_CH-1:0] hit_exp_s;
`ifdef WATCHDOG_WARN_EN
   logic [NUM_CH-1:0] hit_warn_s;
`endif
   logic [NUM_CH-1:0] warn_q;
   logic [NUM_CH-1:0] warn_d;
   logic [NUM_CH-1:0] expired_q;
   logic [NUM_CH-1:0] expired_d;
   logic              expired_any_q;
   logic              expired_any_d;

   // Per-channel timeout slice, incremented count and threshold hits.
   always_comb begin
      for (int i = 0; i < NUM_CH; i++) begin
         tmo_s[i]     = timeout[i*CNT_W +: CNT_W];
         cnt_inc_s[i] = count_q[i] + CNT_ONE;
         // >= rather than == so a corrupted count can never run past T and wrap
         hit_exp_s[i] = (cnt_inc_s[i] >= shadow_q[i]);
`ifdef WATCHDOG_WARN_EN
         hit_warn_s[i] = (33'(shadow_q[i]) > MARGIN_X) &&
                         (cnt_inc_s[i] == (shadow_q[i] - MARGIN_N));
`endif
      end
   end

   // Channel FSMs: next state, count and shadow timeout.
   always_comb begin
      for (int i = 0; i < NUM_CH; i++) begin
         state_d[i]  = state_q[i];
         count_d[i]  = count_q[i];
         shadow_d[i] = shadow_q[i];
         case (state_q[i])
            S_IDLE: begin
               count_d[i] = CNT_ZERO;
               if (en[i] && (tmo_s[i] != CNT_ZERO) && !(clear[i] && kick[i])) begin
                  state_d[i]  = S_RUN;
                  shadow_d[i] = tmo_s[i];
               end else begin
                  state_d[i] = S_IDLE;
               end
            end
`ifdef WATCHDOG_WARN_EN
            S_RUN, S_WARN: begin
`else
            S_RUN: begin
`endif
               if (!en[i] || (clear[i] && kick[i])) begin
                  state_d[i] = S_IDLE;
                  count_d[i] = CNT_ZERO;
               end else if (kick[i]) begin
                  // a zero timeout re-latched by a kick parks the channel
                  count_d[i]  = CNT_ZERO;
                  shadow_d[i] = tmo_s[i];
                  if (tmo_s[i] != CNT_ZERO) begin
                     state_d[i] = S_RUN;
                  end else begin
                     state_d[i] = S_IDLE;
                  end
               end else if (hit_exp_s[i]) begin
                  state_d[i] = S_EXPIRED;
                  count_d[i] = shadow_q[i];
`ifdef WATCHDOG_WARN_EN
               end else if (hit_warn_s[i]) begin
                  state_d[i] = S_WARN;
                  count_d[i] = cnt_inc_s[i];
`endif
               end else begin
                  state_d[i] = state_q[i];
                  count_d[i] = cnt_inc_s[i];
               end
            end
            S_EXPIRED: begin
               if (clear[i]) begin
                  state_d[i] = S_IDLE;
                  count_d[i] = CNT_ZERO;
               end else begin
                  state_d[i] = S_EXPIRED;
               end
            end
            default: begin
               state_d[i] = S_IDLE;
               count_d[i] = CNT_ZERO;
            end
         endcase
      end
   end

   // Output flags decoded from next state so they register coincident with it.
   always_comb begin
      for (int i = 0; i < NUM_CH; i++) begin
`ifdef WATCHDOG_WARN_EN
         warn_d[i] = (state_d[i] == S_WARN);
`else
         warn_d[i] = 1'b0;
`endif
         expired_d[i] = (state_d[i] == S_EXPIRED);
      end
      expired_any_d = |expired_d;
   end

   // State, counter, shadow and output registers.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int i = 0; i < NUM_CH; i++) begin
            state_q[i]  <= S_IDLE;
            count_q[i]  <= CNT_ZERO;
            shadow_q[i] <= CNT_ZERO;
         end
         warn_q        <= {NUM_CH{1'b0}};
         expired_q     <= {NUM_CH{1'b0}};
         expired_any_q <= 1'b0;
      end else begin
         for (int i = 0; i < NUM_CH; i++) begin
            state_q[i]  <= state_d[i];
            count_q[i]  <= count_d[i];
            shadow_q[i] <= shadow_d[i];
         end
         warn_q        <= warn_d;
         expired_q     <= expired_d;
         expired_any_q <= expired_any_d;
      end
   end

   // Pack per-channel counts onto the output bus.
   always_comb begin
      count_val = {(NUM_CH*CNT_W){1'b0}};
      for (int i = 0; i < NUM_CH; i++) begin
         count_val[i*CNT_W +: CNT_W] = count_q[i];
      end
   end

   assign warn        = warn_q;
   assign expired     = expired_q;
   assign expired_any = expired_any_q;

endmodule

// File: tb/tb_watchdog_timer.sv
// Directed self-checking bench for watchdog_timer (NUM_CH=2, CNT_W=10, WARN_MARGIN=8).
`timescale 1ns/1ps
module tb_watchdog_timer;
   localparam int NUM_CH      = 2;
   localparam int CNT_W       = 10;
   localparam int WARN_MARGIN = 8;
`ifdef WATCHDOG_WARN_EN
   localparam bit WARN_ON = 1'b1;
`else
   localparam bit WARN_ON = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic [1:0]  en = 2'b00;
   logic [1:0]  kick = 2'b00;
   logic [1:0]  clear = 2'b00;
   logic [19:0] timeout = 20'd0;
   logic [1:0]  warn;
   logic [1:0]  expired;
   logic        expired_any;
   logic [19:0] count_val;
   logic [9:0]  cnt0;
   logic [9:0]  cnt1;
   int checks = 0;
   int errors = 0;

   assign cnt0 = count_val[9:0];
   assign cnt1 = count_val[19:10];

   always #5 clk = ~clk;

   watchdog_timer #(
      .NUM_CH(NUM_CH), .CNT_W(CNT_W), .WARN_MARGIN(WARN_MARGIN)
   ) dut (
      .clk(clk), .rstn(rstn), .en(en), .kick(kick), .clear(clear),
      .timeout(timeout), .warn(warn), .expired(expired),
      .expired_any(expired_any), .count_val(count_val)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      #12;
      checks++; if (count_val !== 20'd0) begin errors++; $display("FAIL reset_count got %h want 0", count_val); end
      checks++; if (warn !== 2'b00) begin errors++; $display("FAIL reset_warn got %b want 00", warn); end
      checks++; if (expired !== 2'b00) begin errors++; $display("FAIL reset_expired got %b want 00", expired); end
      checks++; if (expired_any !== 1'b0) begin errors++; $display("FAIL reset_any got %b want 0", expired_any); end
      timeout = {10'd10, 10'd20};
      en = 2'b11;
      tick();
      checks++; if (count_val !== 20'd0) begin errors++; $display("FAIL reset_hold_count got %h want 0", count_val); end
      en = 2'b00;
      timeout = 20'd0;
      #2 rstn = 1'b1;
      tick();
      checks++; if (count_val !== 20'd0) begin errors++; $display("FAIL reset_release_count got %h want 0", count_val); end
   endtask

   task automatic test_expiry;
      logic [9:0] exp_c;
      logic       exp_w;
      logic       exp_e;
      timeout[9:0] = 10'd20;
      en[0] = 1'b1;
      tick();
      checks++; if (cnt0 !== 10'd0 || expired[0] !== 1'b0) begin errors++; $display("FAIL expiry_entry got cnt %0d exp %b want 0 0", cnt0, expired[0]); end
      for (int k = 1; k <= 22; k++) begin
         tick();
         exp_c = (k >= 20) ? 10'd20 : 10'(k);
         exp_w = WARN_ON && (k >= 12) && (k < 20);
         exp_e = (k >= 20);
         checks++; if (cnt0 !== exp_c) begin errors++; $display("FAIL expiry_count k=%0d got %0d want %0d", k, cnt0, exp_c); end
         checks++; if (warn[0] !== exp_w) begin errors++; $display("FAIL expiry_warn k=%0d got %b want %b", k, warn[0], exp_w); end
         checks++; if (expired[0] !== exp_e) begin errors++; $display("FAIL expiry_flag k=%0d got %b want %b", k, expired[0], exp_e); end
         checks++; if (expired_any !== exp_e) begin errors++; $display("FAIL expiry_any k=%0d got %b want %b", k, expired_any, exp_e); end
      end
   endtask

   task automatic test_sticky;
      en[0] = 1'b0;
      kick[0] = 1'b1;
      tick();
      kick[0] = 1'b0;
      checks++; if (expired[0] !== 1'b1) begin errors++; $display("FAIL sticky_expired got %b want 1", expired[0]); end
      checks++; if (cnt0 !== 10'd20) begin errors++; $display("FAIL sticky_count got %0d want 20", cnt0); end
      clear[0] = 1'b1;
      tick();
      clear[0] = 1'b0;
      checks++; if (expired[0] !== 1'b0) begin errors++; $display("FAIL clear_expired got %b want 0", expired[0]); end
      checks++; if (expired_any !== 1'b0) begin errors++; $display("FAIL clear_any got %b want 0", expired_any); end
      checks++; if (cnt0 !== 10'd0) begin errors++; $display("FAIL clear_count got %0d want 0", cnt0); end
      tick();
      checks++; if (cnt0 !== 10'd0) begin errors++; $display("FAIL clear_idle_count got %0d want 0", cnt0); end
   endtask

   task automatic test_kick;
      logic [9:0] exp_c;
      logic       exp_w;
      timeout[9:0] = 10'd20;
      en[0] = 1'b1;
      tick();
      repeat (19) tick();
      checks++; if (cnt0 !== 10'd19) begin errors++; $display("FAIL kick_pre_count got %0d want 19", cnt0); end
      checks++; if (warn[0] !== WARN_ON) begin errors++; $display("FAIL kick_pre_warn got %b want %b", warn[0], WARN_ON); end
      kick[0] = 1'b1;
      tick();
      kick[0] = 1'b0;
      checks++; if (cnt0 !== 10'd0) begin errors++; $display("FAIL kick_edge_count got %0d want 0", cnt0); end
      checks++; if (expired[0] !== 1'b0) begin errors++; $display("FAIL kick_edge_expired got %b want 0", expired[0]); end
      checks++; if (warn[0] !== 1'b0) begin errors++; $display("FAIL kick_edge_warn got %b want 0", warn[0]); end
      exp_c = 10'd0;
      for (int c = 0; c < 200; c++) begin
         kick[0] = (exp_c == 10'd14);
         tick();
         exp_c = kick[0] ? 10'd0 : exp_c + 10'd1;
         exp_w = WARN_ON && (exp_c >= 10'd12);
         checks++; if (cnt0 !== exp_c) begin errors++; $display("FAIL kick_loop_count c=%0d got %0d want %0d", c, cnt0, exp_c); end
         checks++; if (expired[0] !== 1'b0) begin errors++; $display("FAIL kick_loop_expired c=%0d got %b want 0", c, expired[0]); end
         checks++; if (warn[0] !== exp_w) begin errors++; $display("FAIL kick_loop_warn c=%0d got %b want %b", c, warn[0], exp_w); end
      end
      kick[0] = 1'b0;
      en[0] = 1'b0;
      tick();
      checks++; if (cnt0 !== 10'd0) begin errors++; $display("FAIL en_drop_count got %0d want 0", cnt0); end
      tick();
      checks++; if (cnt0 !== 10'd0) begin errors++; $display("FAIL en_drop_idle got %0d want 0", cnt0); end
   endtask

   task automatic test_short;
      timeout = {10'd0, 10'd5};
      en = 2'b11;
      tick();
      for (int k = 1; k <= 7; k++) begin
         tick();
         checks++; if (cnt0 !== ((k >= 5) ? 10'd5 : 10'(k))) begin errors++; $display("FAIL short_count k=%0d got %0d", k, cnt0); end
         checks++; if (warn !== 2'b00) begin errors++; $display("FAIL short_warn k=%0d got %b want 00", k, warn); end
         checks++; if (expired !== {1'b0, (k >= 5)}) begin errors++; $display("FAIL short_expired k=%0d got %b want %b", k, expired, {1'b0, (k >= 5)}); end
         checks++; if (cnt1 !== 10'd0) begin errors++; $display("FAIL zero_t_count k=%0d got %0d want 0", k, cnt1); end
      end
      en = 2'b00;
      clear = 2'b01;
      tick();
      clear = 2'b00;
      checks++; if (expired_any !== 1'b0) begin errors++; $display("FAIL short_clear_any got %b want 0", expired_any); end
   endtask

   task automatic test_reset_mid;
      timeout = {10'd0, 10'd20};
      en = 2'b01;
      tick();
      repeat (7) tick();
      checks++; if (cnt0 !== 10'd7) begin errors++; $display("FAIL mid_pre_count got %0d want 7", cnt0); end
      #1 rstn = 1'b0;
      #2;
      checks++; if (count_val !== 20'd0) begin errors++; $display("FAIL mid_reset_count got %h want 0", count_val); end
      checks++; if (warn !== 2'b00 || expired !== 2'b00 || expired_any !== 1'b0) begin errors++; $display("FAIL mid_reset_flags got %b %b %b want 00 00 0", warn, expired, expired_any); end
      #2 rstn = 1'b1;
      tick();
      checks++; if (cnt0 !== 10'd0) begin errors++; $display("FAIL mid_restart_count got %0d want 0", cnt0); end
      tick();
      checks++; if (cnt0 !== 10'd1) begin errors++; $display("FAIL mid_restart_inc got %0d want 1", cnt0); end
      en = 2'b00;
      tick();
   endtask

   task automatic test_independent;
      logic [9:0] e0;
      logic [9:0] e1;
      timeout = {10'd10, 10'd30};
      en = 2'b11;
      tick();
      for (int k = 1; k <= 32; k++) begin
         tick();
         e0 = (k >= 30) ? 10'd30 : 10'(k);
         e1 = (k >= 10) ? 10'd10 : 10'(k);
         checks++; if (cnt0 !== e0 || cnt1 !== e1) begin errors++; $display("FAIL indep_count k=%0d got %0d %0d want %0d %0d", k, cnt0, cnt1, e0, e1); end
         checks++; if (expired !== {(k >= 10), (k >= 30)}) begin errors++; $display("FAIL indep_expired k=%0d got %b want %b", k, expired, {(k >= 10), (k >= 30)}); end
         checks++; if (expired_any !== (k >= 10)) begin errors++; $display("FAIL indep_any k=%0d got %b want %b", k, expired_any, (k >= 10)); end
         checks++; if (warn !== {WARN_ON && k >= 2 && k < 10, WARN_ON && k >= 22 && k < 30}) begin errors++; $display("FAIL indep_warn k=%0d got %b", k, warn); end
         if (k == 3) timeout[9:0] = 10'd5;
      end
      en = 2'b00;
      clear = 2'b11;
      tick();
      clear = 2'b00;
      checks++; if (expired_any !== 1'b0 || count_val !== 20'd0) begin errors++; $display("FAIL indep_clear got any %b cnt %h want 0 0", expired_any, count_val); end
   endtask

   task automatic test_clear_kick;
      timeout = {10'd0, 10'd20};
      en = 2'b01;
      tick();
      tick();
      tick();
      clear[0] = 1'b1;
      tick();
      checks++; if (cnt0 !== 10'd3) begin errors++; $display("FAIL clear_run_noop got %0d want 3", cnt0); end
      kick[0] = 1'b1;
      tick();
      clear[0] = 1'b0;
      kick[0] = 1'b0;
      checks++; if (cnt0 !== 10'd0) begin errors++; $display("FAIL clear_kick_count got %0d want 0", cnt0); end
      tick();
      checks++; if (cnt0 !== 10'd0) begin errors++; $display("FAIL clear_kick_idle got %0d want 0", cnt0); end
      tick();
      checks++; if (cnt0 !== 10'd1) begin errors++; $display("FAIL clear_kick_rerun got %0d want 1", cnt0); end
      en = 2'b00;
      tick();
      checks++; if (cnt0 !== 10'd0 || expired_any !== 1'b0) begin errors++; $display("FAIL clear_kick_end got %0d %b want 0 0", cnt0, expired_any); end
   endtask

   initial begin
      test_reset();
      test_expiry();
      test_sticky();
      test_kick();
      test_short();
      test_reset_mid();
      test_independent();
      test_clear_kick();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
